imm_ext_stage: RTL and testbench
================================

// Module: imm_ext_stage
// PURPOSE
//  Parametrised immediate-generation stage for the decode pipeline. Takes the raw
//  instruction and PC+4 and produces the extended operand in one of six modes:
//  zero, sign, LUI, shamt, branch offset and jump target.
//  The result is registered behind a 2-entry skid buffer with valid/ready on both
//  sides, so decode-to-execute backpressure never creates a combinational ready path.
// PARAMETERS
//  DATA_W   32  operand/PC width (>= 32)
//  IMM_W    16  immediate field width, taken from inst[IMM_W-1:0]
//  TAG_W     5  sideband tag (dest reg) carried alongside the result
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  flush      in   1        sync pipeline flush; drops all buffered entries
//  in_valid   in   1        request valid
//  in_ready   out  1        stage can accept (registered state only)
//  in_inst    in   32       raw instruction word
//  in_pc4     in   DATA_W   PC+4 of the instruction
//  in_mode    in   3        EXT_* mode code (see package)
//  in_tag     in   TAG_W    sideband, passed through unchanged
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts
//  out_data   out  DATA_W   extended operand
//  out_tag    out  TAG_W    tag of out_data
//  out_err    out  1        mode code was illegal; out_data is 0
// BEHAVIOUR
//  Reset (rst_n=0): count=0, out_valid=0, out_data=0, out_tag=0, out_err=0, in_ready=0.
//   in_ready=1 from the first clk edge after release.
//  Modes: EXT_ZERO=0 -> {0, imm}. EXT_SIGN=1 -> {sext imm}.
//   EXT_LUI=2 -> imm << 16, low bits 0. EXT_SHAMT=3 -> zero-ext inst[10:6].
//   EXT_BR=4 -> sext(imm) << 2. EXT_JMP=5 -> {pc4[DATA_W-1:28], inst[25:0], 2'b00}.
//   Codes 5..7: 5 is JMP; 6 and 7 are illegal -> data=0, err=1.
//  Width rule: all shifts are truncated to DATA_W. No overflow flag.
//  Buffer: 2 entries, head=entry0 drives out_*; count in {0,1,2}.
//   in_ready = (count != 2), from registered count only.
//   push = in_valid & in_ready. pop = out_valid & out_ready.
//   out_valid = (count != 0).
//  Latency: an accepted request appears on out_* the next cycle when count was 0,
//   or was 1 with a pop in the same cycle. Otherwise it waits behind the older entry.
//  Ordering: strict FIFO. push+pop at count=1 -> new entry becomes head, count stays 1.
//  Full: count=2 forces in_ready=0, so no push is possible at full.
//  Empty: a pop at count=0 is impossible because out_valid=0. out_data holds its last
//   value (don't-care).
//  flush: next cycle count=0, out_valid=0. It beats a simultaneous push (request
//   dropped) and a simultaneous pop (no effect).
//  Reset mid-transfer: all entries are lost asynchronously. No partial output.
// STRUCTURE
//  Package imm_ext_pkg: EXT_ZERO..EXT_JMP localparams, EXT_MODE_W=3, and a function
//   is_legal_mode().
//  Sub-module imm_ext_core: purely combinational mode mux (inst, pc4, mode ->
//   data, err). It is also reusable in the single-cycle datapath.
//  Top level: imm_ext_core, then the 2-entry skid register file and the count register.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with in_valid=1 -> out_valid=0, in_ready=0; cycle
//    after release in_ready=1.
//  2 Mode sweep, out_ready=1: inst=0x0000_8004, pc4=0xA000_0010.
//    ZERO->0x0000_8004. SIGN->0xFFFF_8004. LUI->0x8004_0000.
//    SHAMT->0x0000_0000. BR->0xFFFE_0010. JMP->0xA002_0010.
//    Each is visible 1 cycle after the handshake.
//  3 Backpressure: out_ready=0, push tags 1,2 -> in_ready=0 after 2nd push; 3rd
//    request held. Release out_ready -> tags exit 1,2,3 in order, no loss, no duplicates.
//  4 Streaming: in_valid=out_ready=1 for 100 random requests -> one result per cycle,
//    matches reference model, in_ready never drops.
//  5 Flush with count=2 and a simultaneous push -> next cycle out_valid=0, and the
//    pushed tag never appears at the output.
//  6 Illegal mode 6 and 7 -> out_err=1, out_data=0. The next legal request has out_err=0.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared mode codes and helpers for the immediate-generation stage.
// The same codes are used by the single-cycle datapath.
package imm_ext_pkg;

  localparam int EXT_MODE_W = 3;

  localparam logic [EXT_MODE_W-1:0] EXT_ZERO  = 3'd0;
  localparam logic [EXT_MODE_W-1:0] EXT_SIGN  = 3'd1;
  localparam logic [EXT_MODE_W-1:0] EXT_LUI   = 3'd2;
  localparam logic [EXT_MODE_W-1:0] EXT_SHAMT = 3'd3;
  localparam logic [EXT_MODE_W-1:0] EXT_BR    = 3'd4;
  localparam logic [EXT_MODE_W-1:0] EXT_JMP   = 3'd5;

  // Codes 6 and 7 are reserved and flagged as errors.
  function automatic logic is_legal_mode(input logic [EXT_MODE_W-1:0] mode);
    return (mode <= EXT_JMP);
  endfunction

endpackage

// File: rtl/imm_ext_stage_if.sv
// Request/result handshake bundle for the immediate-generation stage.
// The producer uses the master modport; the stage itself uses slave.
interface imm_ext_stage_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  import imm_ext_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_inst;
  logic [DATA_W-1:0]     in_pc4;
  logic [EXT_MODE_W-1:0] in_mode;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_err;

  modport master (
    output in_valid, in_inst, in_pc4, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_inst, in_pc4, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

endinterface

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: instruction, PC+4 and mode in,
// extended operand and illegal-mode flag out.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [31:0]           i_inst,
  input  logic [DATA_W-1:0]     i_pc4,
  input  logic [EXT_MODE_W-1:0] i_mode,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_err
);

  logic [IMM_W-1:0]  w_imm;
  logic [DATA_W-1:0] w_zext;
  logic [DATA_W-1:0] w_sext;
  logic              w_unused;

  assign w_imm  = i_inst[IMM_W-1:0];
  assign w_zext = DATA_W'(w_imm);
  assign w_sext = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};

  // Opcode bits and the low PC bits never contribute to any mode.
  assign w_unused = &{1'b0, i_inst[31:26], i_pc4[27:0]};

  always_comb begin
    o_data = '0;
    o_err  = !is_legal_mode(i_mode);
    case (i_mode)
      EXT_ZERO:  o_data = w_zext;
      EXT_SIGN:  o_data = w_sext;
      EXT_LUI:   o_data = w_zext << 16;
      EXT_SHAMT: o_data = DATA_W'(i_inst[10:6]);
      EXT_BR:    o_data = w_sext << 2;
      EXT_JMP:   o_data = {i_pc4[DATA_W-1:28], i_inst[25:0], 2'b00};
      default:   o_data = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Immediate-generation stage: combinational extender followed by a 2-entry
// skid buffer so the consumer's ready never reaches in_ready combinationally.
module imm_ext_stage
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  imm_ext_stage_if.slave bus
);

  logic [DATA_W-1:0] w_data;
  logic              w_err;
  logic              w_push;
  logic              w_pop;
  logic              w_slot;
  logic [1:0]        w_wr;

  logic              r_up;
  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_data [2];
  logic [TAG_W-1:0]  r_tag  [2];
  logic              r_err  [2];

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .i_inst (bus.in_inst),
    .i_pc4  (bus.in_pc4),
    .i_mode (bus.in_mode),
    .o_data (w_data),
    .o_err  (w_err)
  );

  assign bus.in_ready  = r_up && (r_count != 2'd2);
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_data  = r_data[0];
  assign bus.out_tag   = r_tag[0];
  assign bus.out_err   = r_err[0];

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  // New entry lands behind the survivors: slot 1 only when one entry stays.
  assign w_slot = (r_count == 2'd1) && !w_pop;

  for (genvar gi = 0; gi < 2; gi++) begin : g_wr
    assign w_wr[gi] = w_push && (w_slot == 1'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up      <= 1'b0;
      r_count   <= 2'd0;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_tag[0]  <= '0;
      r_tag[1]  <= '0;
      r_err[0]  <= 1'b0;
      r_err[1]  <= 1'b0;
    end else begin
      r_up <= 1'b1;
      if (flush) begin
        r_count <= 2'd0;
      end else begin
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        if (w_wr[0]) begin
          r_data[0] <= w_data;
          r_tag[0]  <= bus.in_tag;
          r_err[0]  <= w_err;
        end else if (w_pop) begin
          r_data[0] <= r_data[1];
          r_tag[0]  <= r_tag[1];
          r_err[0]  <= r_err[1];
        end
        if (w_wr[1]) begin
          r_data[1] <= w_data;
          r_tag[1]  <= bus.in_tag;
          r_err[1]  <= w_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage with a queue-based reference model
// checked against the outputs on every falling clock edge.
module tb_imm_ext_stage;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic up;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  logic [4:0] seen[$];

  imm_ext_stage_if #(.DATA_W(32), .TAG_W(5)) bus ();

  imm_ext_stage #(.DATA_W(32), .IMM_W(16), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference extender written from the mode rules in plain arithmetic.
  function automatic exp_t ref_model(input logic [31:0] inst, input logic [31:0] pc4,
                                     input logic [2:0] mode, input logic [4:0] tag);
    exp_t        e;
    int unsigned imm;
    int          simm;
    imm  = inst & 32'h0000_FFFF;
    simm = (imm >= 32768) ? int'(imm) - 65536 : int'(imm);
    e.tag = tag;
    e.err = 1'b0;
    case (mode)
      3'd0: e.data = imm;
      3'd1: e.data = simm;
      3'd2: e.data = imm * 65536;
      3'd3: e.data = (inst / 64) % 32;
      3'd4: e.data = simm * 4;
      3'd5: e.data = (pc4 & 32'hF000_0000) | ((inst % 32'h0400_0000) * 4);
      default: begin
        e.data = 32'h0;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) up <= 1'b0;
    else        up <= 1'b1;
  end

  // Compare process: occupancy, readiness and head entry every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      check("mon_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      check("mon_in_ready", 32'(bus.in_ready), 32'(up && (q.size() < 2)));
      if (q.size() != 0 && bus.out_valid) begin
        check("mon_data", bus.out_data, q[0].data);
        check("mon_tag", 32'(bus.out_tag), 32'(q[0].tag));
        check("mon_err", 32'(bus.out_err), 32'(q[0].err));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready && q.size() != 0) begin
          $display("pop tag=%0d data=%h err=%0d", bus.out_tag, bus.out_data, bus.out_err);
          seen.push_back(bus.out_tag);
          void'(q.pop_front());
        end
        if (bus.in_valid && bus.in_ready)
          q.push_back(ref_model(bus.in_inst, bus.in_pc4, bus.in_mode, bus.in_tag));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc4,
                      input logic [2:0] mode, input logic [4:0] tag);
    int k;
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc4   = pc4;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 30 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] lits [6];
    int          base;
    lits = '{32'h0000_8004, 32'hFFFF_8004, 32'h8004_0000,
             32'h0000_0000, 32'hFFFE_0010, 32'hA002_0010};
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h0;
    bus.in_pc4    = 32'h0;
    bus.in_mode   = 3'd0;
    bus.in_tag    = 5'd0;
    bus.out_ready = 1'b1;

    // Reset held three cycles with a request pending
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    end
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_out_tag", 32'(bus.out_tag), 32'h0);
    check("rst_out_err", 32'(bus.out_err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check("rel_in_ready_before_edge", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1;
    check("rel_in_ready_after_edge", 32'(bus.in_ready), 32'h1);

    // Mode sweep with literal expectations
    for (int i = 0; i < 6; i++) begin
      check("model_pin", ref_model(32'h0000_8004, 32'hA000_0010, 3'(i), 5'(i)).data, lits[i]);
      send(32'h0000_8004, 32'hA000_0010, 3'(i), 5'(i));
      check("sweep_valid", 32'(bus.out_valid), 32'h1);
      check("sweep_data", bus.out_data, lits[i]);
    end
    @(posedge clk);
    #1;

    // Backpressure: two entries fill the buffer, third waits
    bus.out_ready = 1'b0;
    seen.delete();
    send(32'h0000_0001, 32'h0, 3'd0, 5'd1);
    send(32'h0000_0002, 32'h0, 3'd0, 5'd2);
    check("bp_full_ready", 32'(bus.in_ready), 32'h0);
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h0000_0003;
    bus.in_tag   = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    check("bp_held_ready", 32'(bus.in_ready), 32'h0);
    check("bp_head_tag", 32'(bus.out_tag), 32'h1);
    bus.out_ready = 1'b1;
    send(32'h0000_0003, 32'h0, 3'd0, 5'd3);
    repeat (4) @(posedge clk);
    #1;
    check("bp_count", 32'(seen.size()), 32'h3);
    for (int i = 0; i < 3; i++)
      check("bp_order", (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF, 32'(i + 1));

    // Streaming, one request per cycle
    base = seen.size();
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1;
      bus.in_inst  = $urandom;
      bus.in_pc4   = $urandom;
      bus.in_mode  = 3'($urandom_range(0, 5));
      bus.in_tag   = 5'($urandom_range(0, 31));
      @(negedge clk);
      check("stream_in_ready", 32'(bus.in_ready), 32'h1);
      if (i > 0) check("stream_out_valid", 32'(bus.out_valid), 32'h1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stream_results", 32'(seen.size() - base), 32'd100);

    // Flush at full with a request presented, then at one entry with a real push
    bus.out_ready = 1'b0;
    send(32'h0000_0011, 32'h0, 3'd0, 5'd11);
    send(32'h0000_0012, 32'h0, 3'd0, 5'd12);
    seen.delete();
    bus.in_valid = 1'b1;
    bus.in_tag   = 5'd9;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_full_valid", 32'(bus.out_valid), 32'h0);
    check("flush_full_ready", 32'(bus.in_ready), 32'h1);
    send(32'h0000_0013, 32'h0, 3'd0, 5'd13);
    bus.in_valid = 1'b1;
    bus.in_tag   = 5'd10;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_push_valid", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush_nothing_out", 32'(seen.size()), 32'h0);

    // Illegal modes, then recovery
    send(32'h0000_1234, 32'h0, 3'd6, 5'd20);
    check("ill6_err", 32'(bus.out_err), 32'h1);
    check("ill6_data", bus.out_data, 32'h0);
    send(32'h0000_1234, 32'h0, 3'd7, 5'd21);
    check("ill7_err", 32'(bus.out_err), 32'h1);
    check("ill7_data", bus.out_data, 32'h0);
    send(32'h0000_1234, 32'h0, 3'd0, 5'd22);
    check("legal_err", 32'(bus.out_err), 32'h0);
    check("legal_data", bus.out_data, 32'h0000_1234);
    @(posedge clk);
    #1;

    // Reset mid-transfer drops buffered entries at once
    bus.out_ready = 1'b0;
    send(32'h0000_0031, 32'h0, 3'd0, 5'd1);
    send(32'h0000_0032, 32'h0, 3'd0, 5'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_recover_ready", 32'(bus.in_ready), 32'h1);
    check("midrst_still_empty", 32'(bus.out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
